// File: rtl/settings_bus_arbiter.sv
// -----------------------------------------------------------------------------
// settings_bus_arbiter
//
// Lets C_NUM_MASTERS requesters share one settings register page. The page has
// a registered write port (set_*) and a combinational readback port
// (get_addr -> get_data). Only one transaction is in flight at a time. Masters
// are chosen round-robin. Every accepted read or write ends with a one-cycle
// rsp_valid pulse back to the master that issued it.
//
// Transaction timeline (T = accept cycle):
//   T   : IDLE,  req_ready[g] pulses and the request is captured
//   T+1 : ISSUE, set_*/get_addr present the request, set_stb only for writes
//   T+2 : RESP,  rsp_valid[g] pulses and rsp_data holds readback (0 for writes)
//   T+3 : IDLE,  the earliest next accept
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   req_valid   per-master request
//   req_write   per-master op: 1 = write, 0 = read
//   req_addr    packed addresses, master i at [i*C_ADDRWIDTH +: C_ADDRWIDTH]
//   req_data    packed write data, master i at [i*C_DATAWIDTH +: C_DATAWIDTH]
//   req_ready   one-hot accept pulse (combinational, only in IDLE)
//   rsp_valid   one-hot completion pulse
//   rsp_data    read data for the completing master (shared by all masters)
//   busy        high while a transaction is in flight
//   set_data    write data to the settings page
//   set_addr    write address to the settings page
//   set_stb     write strobe to the settings page
//   get_addr    readback address to the settings page
//   get_data    combinational readback data from the settings page
// -----------------------------------------------------------------------------
module settings_bus_arbiter #(
  parameter int C_DATAWIDTH   = 32,
  parameter int C_ADDRWIDTH   = 32,
  parameter int C_NUM_MASTERS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [C_NUM_MASTERS-1:0]             req_valid,
  input  logic [C_NUM_MASTERS-1:0]             req_write,
  input  logic [C_NUM_MASTERS*C_ADDRWIDTH-1:0] req_addr,
  input  logic [C_NUM_MASTERS*C_DATAWIDTH-1:0] req_data,
  output logic [C_NUM_MASTERS-1:0]             req_ready,
  output logic [C_NUM_MASTERS-1:0]             rsp_valid,
  output logic [C_DATAWIDTH-1:0]               rsp_data,
  output logic                                 busy,
  output logic [C_DATAWIDTH-1:0]               set_data,
  output logic [C_ADDRWIDTH-1:0]               set_addr,
  output logic                                 set_stb,
  output logic [C_ADDRWIDTH-1:0]               get_addr,
  input  logic [C_DATAWIDTH-1:0]               get_data
);

  localparam int unsigned NM = C_NUM_MASTERS;
  localparam int unsigned GW = (C_NUM_MASTERS > 1) ? $clog2(C_NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                   state_q, state_d;
  // Index of the master that won most recently. It is also the owner of the
  // transaction in flight, so no separate grant register is needed.
  logic [GW-1:0]            last_grant_q, last_grant_d;
  logic                     write_q, write_d;
  logic [C_ADDRWIDTH-1:0]   set_addr_q, set_addr_d;
  logic [C_DATAWIDTH-1:0]   set_data_q, set_data_d;
  logic                     set_stb_q, set_stb_d;
  logic [C_ADDRWIDTH-1:0]   get_addr_q, get_addr_d;
  logic [C_NUM_MASTERS-1:0] rsp_valid_q, rsp_valid_d;
  logic [C_DATAWIDTH-1:0]   rsp_data_q, rsp_data_d;

  // ---------------------------------------------------------------------------
  // Round-robin selection
  // ---------------------------------------------------------------------------
  logic          any_req;
  logic [GW-1:0] rr_sel;
  logic          accept;
  int unsigned   rr_idx;
  int unsigned   sel_idx;

  // Walk offsets from the farthest (the last winner itself) down to the
  // nearest (last_grant+1). The last hit is therefore the closest requester
  // after the previous winner, and the previous winner gets the lowest priority.
  always_comb begin
    any_req = 1'b0;
    rr_sel  = '0;
    rr_idx  = 0;
    for (int unsigned off = NM; off >= 1; off--) begin
      rr_idx = 32'(last_grant_q) + off;
      if (rr_idx >= NM) begin
        rr_idx = rr_idx - NM;
      end
      if (req_valid[rr_idx]) begin
        any_req = 1'b1;
        rr_sel  = rr_idx[GW-1:0];
      end
    end
  end

  assign accept  = (state_q == IDLE) && any_req;
  assign sel_idx = 32'(rr_sel);

  // ---------------------------------------------------------------------------
  // Process 1: state register (FSM state plus datapath flops)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NM - 1);
      write_q      <= 1'b0;
      set_addr_q   <= '0;
      set_data_q   <= '0;
      set_stb_q    <= 1'b0;
      get_addr_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      set_addr_q   <= set_addr_d;
      set_data_q   <= set_data_d;
      set_stb_q    <= set_stb_d;
      get_addr_q   <= get_addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = ISSUE;
          last_grant_d = rr_sel;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. The bus registers are loaded at the accept edge, so
  // they show the request during ISSUE and hold it until the next accept. The
  // strobe and response are one-cycle pulses that are cleared by default.
  always_comb begin
    write_d     = write_q;
    set_addr_d  = set_addr_q;
    set_data_d  = set_data_q;
    get_addr_d  = get_addr_q;
    set_stb_d   = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;

    if (accept) begin
      write_d    = req_write[sel_idx];
      set_addr_d = req_addr[sel_idx*C_ADDRWIDTH +: C_ADDRWIDTH];
      set_data_d = req_data[sel_idx*C_DATAWIDTH +: C_DATAWIDTH];
      get_addr_d = req_addr[sel_idx*C_ADDRWIDTH +: C_ADDRWIDTH];
      set_stb_d  = req_write[sel_idx];
    end

    // get_data is valid combinationally during ISSUE, because get_addr_q
    // already points at the captured address.
    if (state_q == ISSUE) begin
      rsp_data_d                = write_q ? '0 : get_data;
      rsp_valid_d[last_grant_q] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 3: outputs
  // ---------------------------------------------------------------------------
  // The ready pulse is masked during reset. Otherwise a request that is valid
  // while rst is high would appear accepted even though the reset drops it.
  always_comb begin
    req_ready = '0;
    if (accept && !rst) begin
      req_ready[rr_sel] = 1'b1;
    end
    busy = (state_q != IDLE);
  end

  assign set_addr  = set_addr_q;
  assign set_data  = set_data_q;
  assign set_stb   = set_stb_q;
  assign get_addr  = get_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule
